// File: rtl/topk_distance_select_if.sv
// Batch-in / drain-out handshake bundle for the top-K distance selector.
// The slave side is the selector, the master side is the producer/consumer.
interface topk_distance_select_if #(
    parameter int DISTANCE_SQ_BIT_WIDTH = 26,
    parameter int BATCH_SIZE = 16,
    parameter int K = 8,
    parameter type METADATA_TYPE = logic
);
    localparam int CW = $clog2(K + 1);

    logic                             in_valid;
    logic                             in_ready;
    logic [DISTANCE_SQ_BIT_WIDTH-1:0] distances_sq [0:BATCH_SIZE-1];
    METADATA_TYPE                     in_metadata [0:BATCH_SIZE-1];
    logic [BATCH_SIZE-1:0]            in_mask;
    logic                             flush;
    logic                             out_valid;
    logic                             out_ready;
    logic [DISTANCE_SQ_BIT_WIDTH-1:0] out_distance_sq;
    METADATA_TYPE                     out_metadata;
    logic                             out_last;
    logic [CW-1:0]                    count;

    modport slave (
        input  in_valid, distances_sq, in_metadata, in_mask,
        input  flush, out_ready,
        output in_ready, out_valid, out_distance_sq,
        output out_metadata, out_last, count
    );

    modport master (
        output in_valid, distances_sq, in_metadata, in_mask,
        output flush, out_ready,
        input  in_ready, out_valid, out_distance_sq,
        input  out_metadata, out_last, count
    );
endinterface

// File: rtl/topk_distance_select.sv
// Streaming top-K selector: inserts one batch element per cycle into a
// sorted K-entry register list and drains it in ascending order.
module topk_distance_select #(
    parameter int DISTANCE_SQ_BIT_WIDTH = 26,
    parameter int BATCH_SIZE = 16,
    parameter int K = 8,
    parameter type METADATA_TYPE = logic
) (
    input logic clk,
    input logic rst,
    topk_distance_select_if.slave bus
);
    localparam int W  = DISTANCE_SQ_BIT_WIDTH;
    localparam int CW = $clog2(K + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int BW = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, INSERT, DRAIN} state_t;

    state_t                state;
    logic [W-1:0]          bat_dist [0:BATCH_SIZE-1];
    METADATA_TYPE          bat_meta [0:BATCH_SIZE-1];
    logic [BATCH_SIZE-1:0] bat_mask;
    logic [BW-1:0]         elem_idx;

    logic [W-1:0]          ent_dist [0:K-1];
    METADATA_TYPE          ent_meta [0:K-1];
    logic [K-1:0]          ent_valid;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         rd_idx;
    logic                  out_valid_q;

    logic [W-1:0]          cur_dist;
    METADATA_TYPE          cur_meta;
    logic                  cur_live;
    logic [K-1:0]          lt;
    logic [K-1:0]          lt_prev;
    logic [W-1:0]          shf_dist [0:K-1];
    METADATA_TYPE          shf_meta [0:K-1];
    logic [K-1:0]          shf_valid;
    logic [W-1:0]          nxt_dist [0:K-1];
    METADATA_TYPE          nxt_meta [0:K-1];
    logic [K-1:0]          nxt_valid;
    logic                  take;
    logic                  last_elem;
    logic                  last_rd;

    // The list is sorted with valid entries first, so lt is monotone and
    // the insert slot is the first set bit of lt.
    always_comb begin
        cur_dist     = bat_dist[elem_idx];
        cur_meta     = bat_meta[elem_idx];
        cur_live     = bat_mask[elem_idx];
        lt           = '0;
        lt_prev      = '0;
        shf_valid    = '0;
        shf_dist[0]  = cur_dist;
        shf_meta[0]  = cur_meta;
        shf_valid[0] = 1'b1;
        for (int j = 0; j < K; j++) begin
            lt[j] = !ent_valid[j] || (cur_dist < ent_dist[j]);
        end
        for (int j = 1; j < K; j++) begin
            lt_prev[j]   = lt[j-1];
            shf_dist[j]  = ent_dist[j-1];
            shf_meta[j]  = ent_meta[j-1];
            shf_valid[j] = ent_valid[j-1];
        end
        for (int j = 0; j < K; j++) begin
            nxt_dist[j]  = ent_dist[j];
            nxt_meta[j]  = ent_meta[j];
            nxt_valid[j] = ent_valid[j];
            if (lt[j]) begin
                nxt_dist[j]  = lt_prev[j] ? shf_dist[j] : cur_dist;
                nxt_meta[j]  = lt_prev[j] ? shf_meta[j] : cur_meta;
                nxt_valid[j] = lt_prev[j] ? shf_valid[j] : 1'b1;
            end
        end
        take      = cur_live && (|lt);
        last_elem = (elem_idx == BW'(BATCH_SIZE - 1));
        last_rd   = ((CW'(rd_idx) + CW'(1)) == cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ent_valid   <= '0;
            cnt         <= '0;
            rd_idx      <= '0;
            elem_idx    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bat_dist <= bus.distances_sq;
                        bat_meta <= bus.in_metadata;
                        bat_mask <= bus.in_mask;
                        elem_idx <= '0;
                        state    <= INSERT;
                    end else if (bus.flush && (cnt != '0)) begin
                        rd_idx      <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                INSERT: begin
                    if (take) begin
                        ent_dist  <= nxt_dist;
                        ent_meta  <= nxt_meta;
                        ent_valid <= nxt_valid;
                        if (cnt != CW'(K)) cnt <= cnt + CW'(1);
                    end
                    if (last_elem) state <= IDLE;
                    else elem_idx <= elem_idx + BW'(1);
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (last_rd) begin
                            ent_valid   <= '0;
                            cnt         <= '0;
                            out_valid_q <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready        = (state == IDLE) && !rst;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_distance_sq = ent_dist[rd_idx];
    assign bus.out_metadata    = ent_meta[rd_idx];
    assign bus.out_last        = out_valid_q && last_rd;
    assign bus.count           = cnt;
endmodule

// File: tb/tb_topk_distance_select.sv
// Directed bench for topk_distance_select with K=4, BATCH_SIZE=4.
// Expected values are hand-derived constants per scenario.
module tb_topk_distance_select;
    typedef logic [3:0] meta_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   k_out;

    logic [25:0] ed [0:3];
    meta_t       em [0:3];

    topk_distance_select_if #(
        .DISTANCE_SQ_BIT_WIDTH(26), .BATCH_SIZE(4),
        .K(4), .METADATA_TYPE(meta_t)
    ) bus ();

    topk_distance_select #(
        .DISTANCE_SQ_BIT_WIDTH(26), .BATCH_SIZE(4),
        .K(4), .METADATA_TYPE(meta_t)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [3:0] mask);
        bus.in_mask  = mask;
        bus.in_valid = 1'b1;
        chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_insert();
        for (int c = 1; c < 4; c++) begin
            chk("insert_busy", 32'(bus.in_ready), 32'd0);
            step();
        end
        chk("insert_done_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("ready_after_batch", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic start_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    task automatic drain_expect(input int n);
        bus.out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_dist", 32'(bus.out_distance_sq), 32'(ed[k]));
            chk("drain_meta", 32'(bus.out_metadata), 32'(em[k]));
            chk("drain_last", 32'(bus.out_last), 32'(k == n - 1));
            step();
        end
        chk("post_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("post_drain_ready", 32'(bus.in_ready), 32'd1);
        chk("post_drain_count", 32'(bus.count), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mask = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.distances_sq = '{26'd0, 26'd0, 26'd0, 26'd0};
        bus.in_metadata = '{4'd0, 4'd0, 4'd0, 4'd0};
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(bus.in_ready), 32'd1);

        // basic sort
        bus.distances_sq = '{26'd50, 26'd10, 26'd30, 26'd20};
        bus.in_metadata = '{4'd0, 4'd1, 4'd2, 4'd3};
        accept(4'b1111);
        wait_insert();
        chk("basic_count", 32'(bus.count), 32'd4);
        ed = '{26'd10, 26'd20, 26'd30, 26'd50};
        em = '{4'd1, 4'd3, 4'd2, 4'd0};
        start_flush();
        drain_expect(4);

        // ties keep arrival order
        bus.distances_sq = '{26'd7, 26'd7, 26'd7, 26'd7};
        bus.in_metadata = '{4'd0, 4'd1, 4'd2, 4'd3};
        accept(4'b1111);
        wait_insert();
        ed = '{26'd7, 26'd7, 26'd7, 26'd7};
        em = '{4'd0, 4'd1, 4'd2, 4'd3};
        start_flush();
        drain_expect(4);

        // overflow and discard
        bus.distances_sq = '{26'd9, 26'd8, 26'd7, 26'd6};
        bus.in_metadata = '{4'd0, 4'd1, 4'd2, 4'd3};
        accept(4'b1111);
        wait_insert();
        bus.distances_sq = '{26'd1, 26'd100, 26'd5, 26'd2};
        bus.in_metadata = '{4'd4, 4'd5, 4'd6, 4'd7};
        accept(4'b1111);
        wait_insert();
        chk("ovf_count", 32'(bus.count), 32'd4);
        ed = '{26'd1, 26'd2, 26'd5, 26'd6};
        em = '{4'd4, 4'd7, 4'd6, 4'd3};
        start_flush();
        drain_expect(4);

        // partial mask
        bus.distances_sq = '{26'd40, 26'd3, 26'd41, 26'd4};
        bus.in_metadata = '{4'd0, 4'd1, 4'd2, 4'd3};
        accept(4'b0101);
        wait_insert();
        chk("mask_count", 32'(bus.count), 32'd2);
        ed = '{26'd40, 26'd41, 26'd0, 26'd0};
        em = '{4'd0, 4'd2, 4'd0, 4'd0};
        start_flush();
        drain_expect(2);

        // backpressure, with in_valid held during the drain
        bus.distances_sq = '{26'd4, 26'd3, 26'd2, 26'd1};
        bus.in_metadata = '{4'd0, 4'd1, 4'd2, 4'd3};
        accept(4'b1111);
        wait_insert();
        ed = '{26'd1, 26'd2, 26'd3, 26'd4};
        em = '{4'd3, 4'd2, 4'd1, 4'd0};
        start_flush();
        k_out = 0;
        for (int c = 0; c < 12; c++) begin
            if (k_out < 4) begin
                bus.out_ready = ((c % 3) == 0);
                bus.in_valid = 1'b1;
                chk("bp_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                chk("bp_dist", 32'(bus.out_distance_sq), 32'(ed[k_out]));
                chk("bp_meta", 32'(bus.out_metadata), 32'(em[k_out]));
                chk("bp_last", 32'(bus.out_last), 32'(k_out == 3));
                if (bus.out_ready) k_out++;
                step();
                bus.in_valid = 1'b0;
            end
        end
        chk("bp_all_drained", 32'(k_out), 32'd4);
        chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_count", 32'(bus.count), 32'd0);

        // batch wins over simultaneous flush, then drain merged list
        bus.distances_sq = '{26'd30, 26'd31, 26'd32, 26'd33};
        bus.in_metadata = '{4'd0, 4'd1, 4'd2, 4'd3};
        accept(4'b0011);
        wait_insert();
        bus.distances_sq = '{26'd5, 26'd35, 26'd6, 26'd36};
        bus.in_metadata = '{4'd4, 4'd5, 4'd6, 4'd7};
        bus.flush = 1'b1;
        accept(4'b1111);
        for (int c = 1; c < 5; c++) begin
            chk("prio_no_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        chk("prio_ready", 32'(bus.in_ready), 32'd1);
        chk("prio_count", 32'(bus.count), 32'd4);
        step();
        bus.flush = 1'b0;
        ed = '{26'd5, 26'd6, 26'd30, 26'd31};
        em = '{4'd4, 4'd6, 4'd0, 4'd1};
        drain_expect(4);

        // reset in the middle of an insert
        bus.out_ready = 1'b0;
        bus.distances_sq = '{26'd5, 26'd6, 26'd7, 26'd8};
        bus.in_metadata = '{4'd0, 4'd1, 4'd2, 4'd3};
        accept(4'b1111);
        step();
        step();
        chk("mid_count", 32'(bus.count), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_after_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_after_count", 32'(bus.count), 32'd0);
        chk("mid_after_valid", 32'(bus.out_valid), 32'd0);
        start_flush();
        chk("mid_flush_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("mid_flush_valid2", 32'(bus.out_valid), 32'd0);
        chk("mid_flush_ready", 32'(bus.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
